// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared widths, BHT counter encodings and saturating helpers
package fetch_pc_unit_pkg;

    localparam int WORD_SIZE = 16;

    typedef logic [WORD_SIZE-1:0] word_t;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } bht_cnt_t;

    function automatic logic [1:0] cnt_sat_inc(input logic [1:0] c);
        return (c == 2'(CNT_ST)) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] cnt_sat_dec(input logic [1:0] c);
        return (c == 2'(CNT_SNT)) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - fetch PC redirect/training/prediction signal bundle
interface fetch_pc_unit_if;
    import fetch_pc_unit_pkg::*;

    logic  stall;
    logic  force_pc;
    word_t force_pc_data;
    logic  upd_valid;
    word_t upd_pc;
    word_t upd_target;
    logic  upd_taken;
    word_t if_pc;
    word_t pred_next_pc;
    logic  pred_taken;
    logic  redirected;

    modport master (
        output stall, force_pc, force_pc_data,
        output upd_valid, upd_pc, upd_target, upd_taken,
        input  if_pc, pred_next_pc, pred_taken, redirected
    );

    modport slave (
        input  stall, force_pc, force_pc_data,
        input  upd_valid, upd_pc, upd_target, upd_taken,
        output if_pc, pred_next_pc, pred_taken, redirected
    );

endinterface

// File: rtl/fetch_pc_unit_btb_table.sv
// rtl/fetch_pc_unit_btb_table.sv - direct-mapped BTB storage, optional 2-bit BHT under FETCH_BHT_2BIT_EN
module fetch_pc_unit_btb_table
    import fetch_pc_unit_pkg::*;
#(
    parameter int IDX_BITS = 4
) (
    input  logic  clk,
    input  logic  reset_n,
    input  word_t rd_pc,
    output logic  rd_hit,
    output word_t rd_target,
    output logic  rd_dir_ok,
    input  logic  wr_en,
    input  word_t wr_pc,
    input  word_t wr_target,
    input  logic  wr_taken
);

    localparam int ENTRIES  = 1 << IDX_BITS;
    localparam int TAG_BITS = WORD_SIZE - IDX_BITS;

    logic [ENTRIES-1:0]                valid_q, valid_d;
    logic [ENTRIES-1:0][TAG_BITS-1:0]  tag_q, tag_d;
    logic [ENTRIES-1:0][WORD_SIZE-1:0] target_q, target_d;

    logic [IDX_BITS-1:0] rd_idx, wr_idx;
    logic [TAG_BITS-1:0] rd_tag, wr_tag;
    logic                wr_hit;

    assign rd_idx    = rd_pc[IDX_BITS-1:0];
    assign rd_tag    = rd_pc[WORD_SIZE-1:IDX_BITS];
    assign wr_idx    = wr_pc[IDX_BITS-1:0];
    assign wr_tag    = wr_pc[WORD_SIZE-1:IDX_BITS];
    assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_target = target_q[rd_idx];
    assign wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

`ifdef FETCH_BHT_2BIT_EN
    logic [ENTRIES-1:0][1:0] cnt_q, cnt_d;
    assign rd_dir_ok = cnt_q[rd_idx][1];
`else
    assign rd_dir_ok = 1'b1;
`endif

    // Training: allocate on taken miss, reinforce on taken hit, weaken or drop on not-taken hit
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
`ifdef FETCH_BHT_2BIT_EN
        cnt_d    = cnt_q;
`endif
        if (wr_en) begin
            if (wr_taken) begin
                valid_d[wr_idx]  = 1'b1;
                tag_d[wr_idx]    = wr_tag;
                target_d[wr_idx] = wr_target;
`ifdef FETCH_BHT_2BIT_EN
                cnt_d[wr_idx]    = wr_hit ? cnt_sat_inc(cnt_q[wr_idx]) : 2'(CNT_WT);
`endif
            end else if (wr_hit) begin
`ifdef FETCH_BHT_2BIT_EN
                cnt_d[wr_idx]    = cnt_sat_dec(cnt_q[wr_idx]);
`else
                valid_d[wr_idx]  = 1'b0;
`endif
            end
        end
    end

    // Valid bits and counters clear asynchronously so a reset invalidates every entry at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
`ifdef FETCH_BHT_2BIT_EN
            cnt_q   <= {ENTRIES{2'(CNT_WNT)}};
`endif
        end else begin
            valid_q <= valid_d;
`ifdef FETCH_BHT_2BIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Tag and target payload is qualified by valid, so it needs no reset
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - IF-stage PC register with BTB next-PC prediction, BHT option FETCH_BHT_2BIT_EN
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int    BTB_IDX_BITS = 4,
    parameter word_t RESET_PC     = '0
) (
    input  logic           clk,
    input  logic           reset_n,
    fetch_pc_unit_if.slave bus
);

    word_t if_pc_q, if_pc_d;
    logic  redirected_q, redirected_d;
    logic  btb_hit, btb_dir_ok, pred_taken;
    word_t btb_target, pred_next_pc;

    fetch_pc_unit_btb_table #(
        .IDX_BITS (BTB_IDX_BITS)
    ) u_btb (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_pc     (if_pc_q),
        .rd_hit    (btb_hit),
        .rd_target (btb_target),
        .rd_dir_ok (btb_dir_ok),
        .wr_en     (bus.upd_valid),
        .wr_pc     (bus.upd_pc),
        .wr_target (bus.upd_target),
        .wr_taken  (bus.upd_taken)
    );

    assign pred_taken   = btb_hit && btb_dir_ok;
    assign pred_next_pc = pred_taken ? btb_target : if_pc_q + word_t'(1);

    // Next PC: a hazard-unit redirect wins even over a stall, then stall holds, else follow prediction
    always_comb begin
        if_pc_d      = pred_next_pc;
        redirected_d = 1'b0;
        if (bus.force_pc) begin
            if_pc_d      = bus.force_pc_data;
            redirected_d = 1'b1;
        end else if (bus.stall) begin
            if_pc_d      = if_pc_q;
        end
    end

    // Fetch PC and redirect flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_pc_q      <= RESET_PC;
            redirected_q <= 1'b0;
        end else begin
            if_pc_q      <= if_pc_d;
            redirected_q <= redirected_d;
        end
    end

    assign bus.if_pc        = if_pc_q;
    assign bus.pred_next_pc = pred_next_pc;
    assign bus.pred_taken   = pred_taken;
    assign bus.redirected   = redirected_q;

endmodule
